// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation searcher.
package sar_search_pkg;

    // FSM encoding; kept as plain constants so older tools can consume it.
    //   state      | meaning
    //   ST_IDLE    | waiting for start, outputs hold
    //   ST_TRIAL   | sample cmp_gt, resolve current bit
    //   ST_WAIT    | comparator settling before the next sample
    //   ST_FINISH  | one-cycle done pulse, result valid
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_TRIAL  = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

    // Bit-index register width: clog2(W), never narrower than one bit.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Settle counter width: clog2(SETTLE+1), never narrower than one bit.
    function automatic int cnt_width(input int settle);
        return (settle > 0) ? $clog2(settle + 1) : 1;
    endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation searcher. Drives a trial word into an external
// greater-than comparator (a = trial, b = unknown target) and resolves the
// target one bit per step, MSB first.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int W      = 4,
    parameter int SETTLE = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         cmp_gt,
    output logic [W-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int IW = idx_width(W);
    localparam int CW = cnt_width(SETTLE);

    localparam logic [W-1:0]  ONE       = W'(1);
    localparam logic [W-1:0]  TRIAL_TOP = ONE << (W - 1);
    localparam logic [IW-1:0] IDX_TOP   = IW'(W - 1);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(SETTLE);

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;

    logic [W-1:0]  bit_cur;
    logic [W-1:0]  bit_nxt;
    logic [W-1:0]  kept;

    // Trial word after resolving the current bit, plus the next bit to try.
    // cmp_gt only reaches state through the TRIAL branch below, so an
    // undriven comparator outside TRIAL cannot leak into trial or result.
    always_comb begin
        bit_cur = ONE << idx;
        bit_nxt = '0;
        if (idx != '0) begin
            bit_nxt = ONE << (idx - IW'(1));
        end
        kept = cmp_gt ? (trial & ~bit_cur) : trial;
    end

    // Search sequencer: one bit resolved per TRIAL visit, optional settle gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            trial  <= '0;
            result <= '0;
            idx    <= IDX_TOP;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        trial <= TRIAL_TOP;
                        idx   <= IDX_TOP;
                        if (SETTLE > 0) begin
                            cnt   <= CNT_LOAD;
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_TRIAL;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_TRIAL;
                    end
                end
                ST_TRIAL: begin
                    if (idx != '0) begin
                        trial <= kept | bit_nxt;
                        idx   <= idx - IW'(1);
                        if (SETTLE > 0) begin
                            cnt   <= CNT_LOAD;
                            state <= ST_WAIT;
                        end
                    end else begin
                        trial  <= kept;
                        result <= kept;
                        state  <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status decode straight from state so busy and done can never overlap.
    always_comb begin
        busy = (state == ST_TRIAL) || (state == ST_WAIT);
        done = (state == ST_FINISH);
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: three instances (W=4/SETTLE=0,
// W=2/SETTLE=0, W=4/SETTLE=2 with a registered comparator).
module tb_sar_search;

    logic clk;
    logic reset;

    logic       start_a, start_b, start_c;
    logic [3:0] target_a, target_c;
    logic [1:0] target_b;
    logic       cmp_a, cmp_b;
    logic       cmp_c = 1'b0;

    logic [3:0] trial_a, result_a, trial_c, result_c;
    logic [1:0] trial_b, result_b;
    logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;

    int total = 0;
    int bad   = 0;

    // Greater-than built from per-bit greater/equal cells, MSB first.
    function automatic logic gt_chain4(input logic [3:0] a, input logic [3:0] b);
        logic gt;
        logic eq;
        gt = 1'b0;
        eq = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            gt = gt | (eq & a[i] & ~b[i]);
            eq = eq & ~(a[i] ^ b[i]);
        end
        return gt;
    endfunction

    assign cmp_a = gt_chain4(trial_a, target_a);
    assign cmp_b = gt_chain4({2'b00, trial_b}, {2'b00, target_b});
    always @(posedge clk) cmp_c <= gt_chain4(trial_c, target_c);

    sar_search #(.W(4), .SETTLE(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .cmp_gt(cmp_a),
        .trial(trial_a), .busy(busy_a), .done(done_a), .result(result_a));

    sar_search #(.W(2), .SETTLE(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cmp_gt(cmp_b),
        .trial(trial_b), .busy(busy_b), .done(done_b), .result(result_b));

    sar_search #(.W(4), .SETTLE(2)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .cmp_gt(cmp_c),
        .trial(trial_c), .busy(busy_c), .done(done_c), .result(result_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (trial_a !== 4'd0) begin bad++; $display("FAIL reset_trial_a got=%0d exp=0", trial_a); end
        total++; if (result_a !== 4'd0) begin bad++; $display("FAIL reset_result_a got=%0d exp=0", result_a); end
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL reset_flags_a busy=%0b done=%0b exp=0/0", busy_a, done_a); end
        total++; if (busy_b !== 1'b0 || done_b !== 1'b0 || result_b !== 2'd0) begin bad++; $display("FAIL reset_b busy=%0b done=%0b result=%0d exp=0/0/0", busy_b, done_b, result_b); end
        total++; if (busy_c !== 1'b0 || done_c !== 1'b0 || trial_c !== 4'd0) begin bad++; $display("FAIL reset_c busy=%0b done=%0b trial=%0d exp=0/0/0", busy_c, done_c, trial_c); end
        reset = 1'b0;
        tick();
    endtask

    // Single search on instance A; cmps[3] is the comparator result in cycle 1.
    task automatic test_walk(input logic [3:0] tgt, input logic [3:0] t0, input logic [3:0] t1,
                             input logic [3:0] t2, input logic [3:0] t3, input logic [3:0] cmps);
        logic [3:0] exp_t [4];
        exp_t = '{t0, t1, t2, t3};
        target_a = tgt;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (trial_a !== exp_t[k]) begin bad++; $display("FAIL walk_trial tgt=%0d cyc=%0d got=%0d exp=%0d", tgt, k + 1, trial_a, exp_t[k]); end
            total++; if (cmp_a !== cmps[3-k]) begin bad++; $display("FAIL walk_cmp tgt=%0d cyc=%0d got=%0b exp=%0b", tgt, k + 1, cmp_a, cmps[3-k]); end
            total++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin bad++; $display("FAIL walk_busy tgt=%0d cyc=%0d busy=%0b done=%0b exp=1/0", tgt, k + 1, busy_a, done_a); end
            tick();
        end
        total++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin bad++; $display("FAIL walk_done tgt=%0d done=%0b busy=%0b exp=1/0", tgt, done_a, busy_a); end
        total++; if (result_a !== tgt) begin bad++; $display("FAIL walk_result got=%0d exp=%0d", result_a, tgt); end
        total++; if (trial_a !== tgt) begin bad++; $display("FAIL walk_final_trial got=%0d exp=%0d", trial_a, tgt); end
        tick();
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL walk_done_pulse tgt=%0d done=%0b exp=0", tgt, done_a); end
    endtask

    task automatic test_back_to_back_a();
        int n;
        target_a = 4'd0;
        start_a  = 1'b1;
        for (int t = 0; t < 16; t++) begin
            n = 0;
            do begin tick(); n++; end while (!done_a && n < 20);
            total++; if (done_a !== 1'b1) begin bad++; $display("FAIL b2b_a_timeout tgt=%0d cycles=%0d exp_done=1", t, n); end
            total++; if (n != ((t == 0) ? 5 : 6)) begin bad++; $display("FAIL b2b_a_spacing tgt=%0d got=%0d exp=%0d", t, n, (t == 0) ? 5 : 6); end
            total++; if (result_a !== 4'(t)) begin bad++; $display("FAIL b2b_a_result got=%0d exp=%0d", result_a, t); end
            target_a = 4'(t + 1);
        end
        start_a = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back_b();
        int n;
        target_b = 2'd0;
        start_b  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            do begin tick(); n++; end while (!done_b && n < 20);
            total++; if (done_b !== 1'b1) begin bad++; $display("FAIL b2b_b_timeout tgt=%0d cycles=%0d exp_done=1", t, n); end
            total++; if (n != ((t == 0) ? 3 : 4)) begin bad++; $display("FAIL b2b_b_spacing tgt=%0d got=%0d exp=%0d", t, n, (t == 0) ? 3 : 4); end
            total++; if (result_b !== 2'(t)) begin bad++; $display("FAIL b2b_b_result got=%0d exp=%0d", result_b, t); end
            target_b = 2'(t + 1);
        end
        start_b = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_ignored_start();
        int ndone;
        int done_cyc;
        ndone    = 0;
        done_cyc = -1;
        target_a = 4'd9;
        start_a  = 1'b1;
        tick();
        for (int c = 1; c <= 12; c++) begin
            start_a = (c == 2 || c == 5);
            if (done_a) begin ndone++; done_cyc = c; end
            tick();
        end
        start_a = 1'b0;
        total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        total++; if (done_cyc != 5) begin bad++; $display("FAIL ignore_done_cycle got=%0d exp=5", done_cyc); end
        total++; if (result_a !== 4'd9) begin bad++; $display("FAIL ignore_result got=%0d exp=9", result_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL ignore_idle busy=%0b exp=0", busy_a); end
    endtask

    task automatic test_reset_mid();
        target_a = 4'd12;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        tick();
        tick();
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy got=%0b exp=1", busy_a); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (trial_a !== 4'd0 || result_a !== 4'd0) begin bad++; $display("FAIL midrst_words trial=%0d result=%0d exp=0/0", trial_a, result_a); end
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL midrst_flags busy=%0b done=%0b exp=0/0", busy_a, done_a); end
        tick();
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL midrst_idle busy=%0b done=%0b exp=0/0", busy_a, done_a); end
        test_walk(4'd5, 4'd8, 4'd4, 4'd6, 4'd5, 4'b1010);
    endtask

    task automatic test_settle();
        logic [3:0] exp_t [12];
        exp_t = '{4'd8, 4'd8, 4'd8, 4'd12, 4'd12, 4'd12, 4'd10, 4'd10, 4'd10, 4'd11, 4'd11, 4'd11};
        target_c = 4'd10;
        start_c  = 1'b1;
        tick();
        start_c  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            total++; if (trial_c !== exp_t[k] || busy_c !== 1'b1 || done_c !== 1'b0) begin
                bad++; $display("FAIL settle_step cyc=%0d trial=%0d busy=%0b done=%0b exp=%0d/1/0", k + 1, trial_c, busy_c, done_c, exp_t[k]);
            end
            tick();
        end
        total++; if (done_c !== 1'b1 || busy_c !== 1'b0) begin bad++; $display("FAIL settle_done cyc=13 done=%0b busy=%0b exp=1/0", done_c, busy_c); end
        total++; if (result_c !== 4'd10) begin bad++; $display("FAIL settle_result got=%0d exp=10", result_c); end
        tick();
        total++; if (done_c !== 1'b0) begin bad++; $display("FAIL settle_done_pulse got=%0b exp=0", done_c); end
    endtask

    initial begin
        reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        start_c  = 1'b0;
        target_a = 4'd0;
        target_b = 2'd0;
        target_c = 4'd0;
        test_reset();
        test_walk(4'd6,  4'd8, 4'd4,  4'd6,  4'd7,  4'b1001);
        test_walk(4'd0,  4'd8, 4'd4,  4'd2,  4'd1,  4'b1111);
        test_walk(4'd15, 4'd8, 4'd12, 4'd14, 4'd15, 4'b0000);
        test_walk(4'd9,  4'd8, 4'd12, 4'd10, 4'd9,  4'b0110);
        test_back_to_back_a();
        test_back_to_back_b();
        test_ignored_start();
        test_reset_mid();
        test_settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
